// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and defaults for the cache-to-memory arbiter.
package cache_mem_arbiter_pkg;

  localparam int unsigned ADDR_W_DEFAULT    = 32;
  localparam int unsigned WORD_W_DEFAULT    = 8;
  localparam int unsigned BURST_LEN_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    RELEASE
  } arb_state_t;

  typedef enum logic {
    REQ_I,
    REQ_D
  } requester_t;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Cache request/response and memory beat signals shared by the arbiter and its neighbours.
interface cache_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned WORD_W = 8
);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [WORD_W-1:0] i_rdata;
  logic              i_valid;
  logic              i_done;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [WORD_W-1:0] d_wdata;
  logic              d_wready;
  logic [WORD_W-1:0] d_rdata;
  logic              d_valid;
  logic              d_done;

  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [WORD_W-1:0] m_wdata;
  logic [WORD_W-1:0] m_rdata;
  logic              m_ack;

  // Arbiter side
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
    output i_rdata, i_valid, i_done, d_wready, d_rdata, d_valid, d_done,
           m_req, m_we, m_addr, m_wdata
  );

  // Caches and memory side
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
    input  i_rdata, i_valid, i_done, d_wready, d_rdata, d_valid, d_done,
           m_req, m_we, m_addr, m_wdata
  );

endinterface

// File: rtl/cache_mem_arbiter_rr_arbiter2.sv
// Two-input round-robin grant; the last winner loses the next tie.
module rr_arbiter2
  import cache_mem_arbiter_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       i_req_i,
  input  logic       d_req_i,
  input  logic       update_i,
  input  requester_t owner_i,
  output logic       gnt_valid_c,
  output requester_t gnt_c
);

  requester_t last_q;
  requester_t last_d;

  assign last_d = update_i ? owner_i : last_q;

  // Reset favours D on the first contention
  always_ff @(posedge clock) begin
    if (reset) last_q <= REQ_I;
    else       last_q <= last_d;
  end

  always_comb begin
    gnt_valid_c = i_req_i | d_req_i;
    gnt_c       = REQ_I;
    if (i_req_i && d_req_i) gnt_c = (last_q == REQ_I) ? REQ_D : REQ_I;
    else if (d_req_i)       gnt_c = REQ_D;
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one memory port between I and D caches, sequencing fixed-length line bursts.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEFAULT,
  parameter int unsigned WORD_W    = WORD_W_DEFAULT,
  parameter int unsigned BURST_LEN = BURST_LEN_DEFAULT
) (
  input logic               clock,
  input logic               reset,
  cache_mem_arbiter_if.slave bus
);

  localparam int unsigned     BEAT_W    = $clog2(BURST_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(BURST_LEN - 1);

  arb_state_t        state_q, state_d;
  requester_t        owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [BEAT_W-1:0] beat_q, beat_d;

  logic              gnt_valid_c;
  requester_t        gnt_c;
  logic              arb_update_c;

  rr_arbiter2 u_rr (
    .clock       (clock),
    .reset       (reset),
    .i_req_i     (bus.i_req),
    .d_req_i     (bus.d_req),
    .update_i    (arb_update_c),
    .owner_i     (owner_q),
    .gnt_valid_c (gnt_valid_c),
    .gnt_c       (gnt_c)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= REQ_I;
      we_q    <= 1'b0;
      base_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      base_q  <= base_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    base_d       = base_q;
    beat_d       = beat_q;
    arb_update_c = 1'b0;

    bus.i_rdata  = {WORD_W{1'b0}};
    bus.i_valid  = 1'b0;
    bus.i_done   = 1'b0;
    bus.d_rdata  = {WORD_W{1'b0}};
    bus.d_valid  = 1'b0;
    bus.d_wready = 1'b0;
    bus.d_done   = 1'b0;
    bus.m_req    = 1'b0;
    bus.m_we     = 1'b0;
    bus.m_addr   = base_q | ADDR_W'(beat_q);
    bus.m_wdata  = bus.d_wdata;

    unique case (state_q)
      IDLE: begin
        if (gnt_valid_c) begin
          owner_d = gnt_c;
          beat_d  = '0;
          state_d = XFER;
          if (gnt_c == REQ_D) begin
            base_d = bus.d_addr & LINE_MASK;
            we_d   = bus.d_we;
          end else begin
            base_d = bus.i_addr & LINE_MASK;
            we_d   = 1'b0;
          end
        end
      end
      XFER: begin
        bus.m_req = 1'b1;
        bus.m_we  = we_q;
        if (bus.m_ack) begin
          beat_d = beat_q + BEAT_W'(1);
          if (we_q) begin
            bus.d_wready = 1'b1;
          end else if (owner_q == REQ_D) begin
            bus.d_valid = 1'b1;
            bus.d_rdata = bus.m_rdata;
          end else begin
            bus.i_valid = 1'b1;
            bus.i_rdata = bus.m_rdata;
          end
          if (beat_q == LAST_BEAT) state_d = RELEASE;
        end
      end
      RELEASE: begin
        arb_update_c = 1'b1;
        if (owner_q == REQ_D) bus.d_done = 1'b1;
        else                  bus.i_done = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: table of single-requester bursts plus arbitration corner cases.
module tb_cache_mem_arbiter;

  logic clk;
  logic reset;
  int   nvec;
  int   nerr;

  cache_mem_arbiter_if #(.ADDR_W(32), .WORD_W(8)) bus ();

  cache_mem_arbiter #(.ADDR_W(32), .WORD_W(8), .BURST_LEN(4)) dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] exp_base;
    logic [7:0]  d0;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called one cycle after the request was sampled; returns in the RELEASE cycle.
  task automatic burst(input bit is_d, input bit we, input logic [31:0] base, input logic [7:0] d0,
                       input int stall_beat, input int stall_n, input bit drop);
    for (int b = 0; b < 4; b++) begin
      if (b == stall_beat) begin
        for (int s = 0; s < stall_n; s++) begin
          bus.m_ack   = 1'b0;
          bus.m_rdata = 8'hEE;
          #1;
          chk("stall_m_req", 32'(bus.m_req), 32'd1);
          chk("stall_m_addr", bus.m_addr, base + 32'(b));
          chk("stall_valid", 32'({bus.i_valid, bus.d_valid, bus.d_wready}), 32'd0);
          chk("stall_done", 32'({bus.i_done, bus.d_done}), 32'd0);
          tick();
        end
      end
      bus.m_ack   = 1'b1;
      bus.m_rdata = d0 + 8'(b);
      bus.d_wdata = d0 + 8'(b);
      #1;
      chk("m_req", 32'(bus.m_req), 32'd1);
      chk("m_addr", bus.m_addr, base + 32'(b));
      chk("m_we", 32'(bus.m_we), 32'(we));
      if (is_d) begin
        chk("d_valid", 32'(bus.d_valid), 32'(!we));
        chk("d_wready", 32'(bus.d_wready), 32'(we));
        chk("d_rdata", 32'(bus.d_rdata), we ? 32'd0 : 32'(d0 + 8'(b)));
        if (we) chk("m_wdata", 32'(bus.m_wdata), 32'(d0 + 8'(b)));
        chk("i_valid_idle", 32'(bus.i_valid), 32'd0);
        chk("i_rdata_idle", 32'(bus.i_rdata), 32'd0);
      end else begin
        chk("i_valid", 32'(bus.i_valid), 32'd1);
        chk("i_rdata", 32'(bus.i_rdata), 32'(d0 + 8'(b)));
        chk("d_out_idle", 32'({bus.d_valid, bus.d_wready}), 32'd0);
        chk("d_rdata_idle", 32'(bus.d_rdata), 32'd0);
      end
      chk("done_early", 32'({bus.i_done, bus.d_done}), 32'd0);
      if (drop && b == 0) begin
        if (is_d) bus.d_req = 1'b0;
        else      bus.i_req = 1'b0;
      end
      tick();
    end
    bus.m_ack = 1'b0;
    #1;
    chk("rel_m_req", 32'(bus.m_req), 32'd0);
    chk("i_done", 32'(bus.i_done), 32'(!is_d));
    chk("d_done", 32'(bus.d_done), 32'(is_d));
    chk("rel_valid", 32'({bus.i_valid, bus.d_valid, bus.d_wready}), 32'd0);
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    vecs[0] = '{is_d: 1'b0, we: 1'b0, addr: 32'h0000_1007, exp_base: 32'h0000_1004, d0: 8'hA0};
    vecs[1] = '{is_d: 1'b1, we: 1'b1, addr: 32'h0000_2000, exp_base: 32'h0000_2000, d0: 8'h11};
    vecs[2] = '{is_d: 1'b1, we: 1'b0, addr: 32'h0000_30F5, exp_base: 32'h0000_30F4, d0: 8'h50};
    vecs[3] = '{is_d: 1'b0, we: 1'b0, addr: 32'hFFFF_FFFE, exp_base: 32'hFFFF_FFFC, d0: 8'hC0};
    vecs[4] = '{is_d: 1'b1, we: 1'b1, addr: 32'h0000_000B, exp_base: 32'h0000_0008, d0: 8'hF0};

    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.m_rdata = '0; bus.m_ack = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_m_req", 32'(bus.m_req), 32'd0);
    chk("rst_m_we", 32'(bus.m_we), 32'd0);
    chk("rst_m_addr", bus.m_addr, 32'd0);
    chk("rst_flags", 32'({bus.i_valid, bus.i_done, bus.d_valid, bus.d_wready, bus.d_done}), 32'd0);
    chk("rst_rdata", 32'({bus.i_rdata, bus.d_rdata}), 32'd0);

    // Single-requester bursts
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].is_d) begin
        bus.d_req = 1'b1; bus.d_we = vecs[v].we; bus.d_addr = vecs[v].addr;
      end else begin
        bus.i_req = 1'b1; bus.i_addr = vecs[v].addr; bus.d_we = 1'b1;
      end
      #1;
      chk("idle_m_req", 32'(bus.m_req), 32'd0);
      tick();
      burst(vecs[v].is_d, vecs[v].we, vecs[v].exp_base, vecs[v].d0, -1, 0, 1'b0);
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
      tick();
      chk("done_pulse", 32'({bus.i_done, bus.d_done}), 32'd0);
      chk("gap_m_req", 32'(bus.m_req), 32'd0);
    end

    // Contention after reset: D, I, D with both held
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_0100;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_0203;
    tick();
    burst(1'b1, 1'b0, 32'h0000_0200, 8'h30, -1, 0, 1'b0);
    tick();
    chk("fair_gap", 32'(bus.m_req), 32'd0);
    tick();
    burst(1'b0, 1'b0, 32'h0000_0100, 8'h40, -1, 0, 1'b0);
    tick();
    tick();
    burst(1'b1, 1'b0, 32'h0000_0200, 8'h50, -1, 0, 1'b0);
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    tick();

    // Reset after beat 1 of an I fill; last winner was D, reset must restore D priority
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_0500;
    tick();
    bus.m_ack = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    bus.m_ack = 1'b0;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h0000_0600;
    tick();
    chk("rstmid_m_req", 32'(bus.m_req), 32'd0);
    chk("rstmid_done", 32'({bus.i_done, bus.d_done}), 32'd0);
    reset = 1'b0;
    tick();
    burst(1'b1, 1'b1, 32'h0000_0600, 8'h70, -1, 0, 1'b0);
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    tick();

    // Memory stall of 5 cycles on beat 2
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_0404;
    tick();
    burst(1'b0, 1'b0, 32'h0000_0404, 8'h60, 2, 5, 1'b0);
    bus.i_req = 1'b0;
    tick();

    // Request dropped after beat 0
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_0700;
    tick();
    burst(1'b0, 1'b0, 32'h0000_0700, 8'h80, -1, 0, 1'b1);
    tick();
    chk("drop_idle", 32'(bus.m_req), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single next-level memory port between the instruction cache and the data cache.
- Each cache raises a line-transfer request on a miss (fills) or an eviction (data writebacks).
- The arbiter grants one requester at a time, using round-robin priority.
- It sequences a fixed-length burst of BURST_LEN word beats to memory and signals completion back to the granted cache.

Parameters:
- ADDR_W, 32, address width (matches the cache ADDRSPACE).
- WORD_W, 8, data width per beat (matches the cache WORD).
- BURST_LEN, 4, beats per line transfer. Must be a power of two and at least 2.

Ports:
- clock  in  1  system clock. All logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- i_req  in  1  instruction cache line-fill request. Read only.
- i_addr  in  ADDR_W  instruction fill address.
- i_rdata  out  WORD_W  fill beat data.
- i_valid  out  1  i_rdata valid this cycle.
- i_done  out  1  one-cycle pulse: instruction transfer complete.
- d_req  in  1  data cache request.
- d_we  in  1  1 = writeback, 0 = fill.
- d_addr  in  ADDR_W  data transfer address.
- d_wdata  in  WORD_W  writeback beat data.
- d_wready  out  1  d_wdata consumed this cycle; the cache advances to the next beat.
- d_rdata  out  WORD_W  fill beat data.
- d_valid  out  1  d_rdata valid this cycle.
- d_done  out  1  one-cycle pulse: data transfer complete.
- m_req  out  1  memory beat request.
- m_we  out  1  memory write enable.
- m_addr  out  ADDR_W  memory beat address.
- m_wdata  out  WORD_W  memory write data.
- m_rdata  in  WORD_W  memory read data.
- m_ack  in  1  memory accepted or returned the current beat.

Behaviour:
- FSM states: IDLE, XFER, RELEASE. Reset returns to IDLE from any state, including mid-burst.
- Reset values:
  - m_req=0, m_we=0, m_addr=0.
  - all valid, ready and done outputs = 0; rdata outputs = 0.
  - beat counter = 0.
  - last_grant = I, so D wins the first contention.
- IDLE:
  - Requests are sampled only in IDLE.
  - If exactly one request is high, grant it.
  - If both are high, grant the one that is not last_grant.
  - On grant, latch owner, the aligned base address (addr with its low log2(BURST_LEN) bits zeroed) and we (0 for I).
  - Load beat=0 and go to XFER. m_req asserts the cycle after the request is sampled.
- XFER:
  - m_req=1, m_we=latched we, m_addr=base | beat.
  - m_wdata is combinationally d_wdata.
  - On m_ack:
    - reads: owner x_valid=1 and x_rdata=m_rdata, combinational, same cycle.
    - writes: d_wready=1.
    - beat increments. On the ack of beat BURST_LEN-1, go to RELEASE.
  - Without m_ack, all outputs hold. There is no timeout.
- RELEASE:
  - m_req=0. Owner's x_done=1 for exactly one cycle; last_grant=owner.
  - Next state is IDLE unconditionally.
  - Minimum gap between bursts is 2 cycles (RELEASE, IDLE).
- Requester rules:
  - Hold req and addr stable until done.
  - Deassert req in the cycle after done.
  - req high during RELEASE is not sampled.
  - Dropping req mid-burst is ignored; the burst completes.
- The non-owner's valid, wready and done outputs stay 0 throughout.
- The beat counter is log2(BURST_LEN) bits wide; there is no carry into the base address, so addresses never cross a line.
- Back-to-back fairness: if both requests stay high, grants alternate D, I, D, I.

Decomposition:
- cachepkg gains:
  - typedef enum arb_state_t {IDLE, XFER, RELEASE}.
  - typedef enum requester_t {REQ_I, REQ_D}.
  - localparam BURST_LEN_DEFAULT = 4.
- One sub-module, rr_arbiter2: a 2-input round-robin grant with a last_grant register and an update enable.
- The FSM and beat counter stay in cache_mem_arbiter.

Test Plan:
- I-only fill:
  - Stimulus: i_req=1, i_addr=0x1007; memory acks every cycle with rdata 0xA0..0xA3.
  - Required: m_addr 0x1004..0x1007, m_we=0; i_valid on 4 consecutive cycles with data 0xA0..0xA3; i_done one cycle after the last ack; d_* outputs stay 0.
- D writeback:
  - Stimulus: d_req=1, d_we=1, d_addr=0x2000; the cache steps d_wdata 0x11..0x14 on d_wready.
  - Required: m_we=1, m_wdata sequence 0x11..0x14 at 0x2000..0x2003, then d_done.
- Simultaneous request after reset:
  - Stimulus: i_req and d_req both high.
  - Required: D granted first; after d_done, I granted; with both held, the third grant is D.
- Memory stall:
  - Stimulus: m_ack low for 5 cycles during beat 2.
  - Required: m_addr holds base+2, no valid pulses, completion delayed exactly 5 cycles.
- Reset mid-burst:
  - Stimulus: reset asserted after beat 1.
  - Required: next cycle m_req=0 and no done pulse; after reset with both requests high, D is granted.
- Req dropped mid-burst:
  - Stimulus: i_req falls after beat 0.
  - Required: all 4 beats still issued and i_done pulses.
